udm_bus_initiator: RTL and testbench

//   Master side of the udm-style on-chip bus (req/we/addr/be/wdata/ack/resp/rdata).

---
 rtl/udm_bus_initiator.sv | 156 +++++++++++++++
 tb/tb_udm_bus_initiator.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udm_bus_initiator.sv
// Bus master for the udm-style on-chip bus: takes one command at a time from a
// req/ack stream, runs one bus transaction and returns one response beat.
module udm_bus_initiator #(
  parameter int unsigned BUS_TIMEOUT   = 1024,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_req_i,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_bi,
  input  logic [3:0]  cmd_be_bi,
  input  logic [31:0] cmd_wdata_bi,
  output logic        cmd_ack_o,
  output logic        rsp_req_o,
  output logic [31:0] rsp_rdata_bo,
  output logic        rsp_err_o,
  input  logic        rsp_ack_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_bo,
  output logic [3:0]  bus_be_bo,
  output logic [31:0] bus_wdata_bo,
  input  logic        bus_ack_i,
  input  logic        bus_resp_i,
  input  logic [31:0] bus_rdata_bi,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(BUS_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RESP, S_RSP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          timeout;
  logic          bus_req_d, bus_we_d, rsp_req_d, rsp_err_d, busy_d;
  logic [31:0]   bus_addr_d, bus_wdata_d, rsp_rdata_d;
  logic [3:0]    bus_be_d;

  // Gated by reset so no command is accepted while the block is held in reset
  assign cmd_ack_o = (state_q == S_IDLE) & rst_ni;

  // Saturating counter and timeout detect for the REQ/WAIT_RESP window
  assign cnt_inc = (cnt_q == CW'(BUS_TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
  assign timeout = (cnt_q == CW'(BUS_TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_bo  <= '0;
      bus_be_bo    <= '0;
      bus_wdata_bo <= '0;
      rsp_req_o    <= 1'b0;
      rsp_rdata_bo <= '0;
      rsp_err_o    <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_req_o    <= bus_req_d;
      bus_we_o     <= bus_we_d;
      bus_addr_bo  <= bus_addr_d;
      bus_be_bo    <= bus_be_d;
      bus_wdata_bo <= bus_wdata_d;
      rsp_req_o    <= rsp_req_d;
      rsp_rdata_bo <= rsp_rdata_d;
      rsp_err_o    <= rsp_err_d;
      busy_o       <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_o;
    bus_we_d    = bus_we_o;
    bus_addr_d  = bus_addr_bo;
    bus_be_d    = bus_be_bo;
    bus_wdata_d = bus_wdata_bo;
    rsp_req_d   = rsp_req_o;
    rsp_rdata_d = rsp_rdata_bo;
    rsp_err_d   = rsp_err_o;

    case (state_q)
      S_IDLE: begin
        if (cmd_req_i && cmd_ack_o) begin
          bus_req_d   = 1'b1;
          bus_we_d    = cmd_we_i;
          bus_addr_d  = cmd_addr_bi;
          bus_be_d    = cmd_be_bi;
          bus_wdata_d = cmd_wdata_bi;
          cnt_d       = '0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        // A completing ack takes priority over a timeout in the same cycle
        if (bus_ack_i) begin
          bus_req_d = 1'b0;
          if (bus_we_o) begin
            rsp_req_d   = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
            state_d     = S_RSP;
          end else if (bus_resp_i) begin
            rsp_req_d   = 1'b1;
            rsp_rdata_d = bus_rdata_bi;
            rsp_err_d   = 1'b0;
            state_d     = S_RSP;
          end else begin
            state_d = S_WAIT_RESP;
          end
        end else if (timeout) begin
          bus_req_d   = 1'b0;
          rsp_req_d   = 1'b1;
          rsp_rdata_d = TIMEOUT_RDATA;
          rsp_err_d   = 1'b1;
          state_d     = S_RSP;
        end
      end
      S_WAIT_RESP: begin
        cnt_d = cnt_inc;
        if (bus_resp_i) begin
          rsp_req_d   = 1'b1;
          rsp_rdata_d = bus_rdata_bi;
          rsp_err_d   = 1'b0;
          state_d     = S_RSP;
        end else if (timeout) begin
          rsp_req_d   = 1'b1;
          rsp_rdata_d = TIMEOUT_RDATA;
          rsp_err_d   = 1'b1;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ack_i) begin
          rsp_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_be_d    = '0;
          bus_wdata_d = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_udm_bus_initiator.sv
// Self-checking bench for udm_bus_initiator; expected responses are queued when
// commands are accepted and compared when the response beat appears.
module tb_udm_bus_initiator;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk_gen;
  logic        rst_ni;
  logic        cmd_req_i, cmd_we_i;
  logic [31:0] cmd_addr_bi, cmd_wdata_bi;
  logic [3:0]  cmd_be_bi;
  logic        cmd_ack_o;
  logic        rsp_req_o, rsp_err_o, rsp_ack_i;
  logic [31:0] rsp_rdata_bo;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_bo, bus_wdata_bo;
  logic [3:0]  bus_be_bo;
  logic        bus_ack_i, bus_resp_i;
  logic [31:0] bus_rdata_bi;
  logic        busy_o;

  int   n_checks;
  int   n_fail;
  rsp_t exp_q[$];

  udm_bus_initiator #(.BUS_TIMEOUT(8), .TIMEOUT_RDATA(32'hDEADBEEF)) dut (
    .clk_i(clk_gen), .rst_ni(rst_ni),
    .cmd_req_i(cmd_req_i), .cmd_we_i(cmd_we_i), .cmd_addr_bi(cmd_addr_bi),
    .cmd_be_bi(cmd_be_bi), .cmd_wdata_bi(cmd_wdata_bi), .cmd_ack_o(cmd_ack_o),
    .rsp_req_o(rsp_req_o), .rsp_rdata_bo(rsp_rdata_bo), .rsp_err_o(rsp_err_o),
    .rsp_ack_i(rsp_ack_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_bo(bus_addr_bo),
    .bus_be_bo(bus_be_bo), .bus_wdata_bo(bus_wdata_bo), .bus_ack_i(bus_ack_i),
    .bus_resp_i(bus_resp_i), .bus_rdata_bi(bus_rdata_bi), .busy_o(busy_o)
  );

  initial clk_gen = 1'b0;
  always #5 clk_gen = ~clk_gen;

  // Pops the next expected response; an empty queue yields X so the compare fails
  task automatic pop_exp(output rsp_t e);
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
    cmd_req_i = 1'b1; cmd_we_i = we; cmd_addr_bi = addr; cmd_be_bi = be; cmd_wdata_bi = wdata;
  endtask

  task automatic test_reset;
    logic [134:0] outs;
    rst_ni = 1'b0;
    @(negedge clk_gen);
    outs = {cmd_ack_o, rsp_req_o, rsp_rdata_bo, rsp_err_o, bus_req_o, bus_we_o,
            bus_addr_bo, bus_be_bo, bus_wdata_bo, busy_o};
    n_checks++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    rst_ni = 1'b1;
    @(negedge clk_gen);
    n_checks++;
    if (cmd_ack_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: cmd_ack=%b busy=%b expected 1 0", cmd_ack_o, busy_o);
    end
  endtask

  task automatic test_write;
    rsp_t e;
    @(negedge clk_gen);
    send_cmd(1'b1, 32'h8000_0004, 4'hF, 32'h1234_5678);
    bus_ack_i = 1'b1;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    @(negedge clk_gen);
    cmd_req_i = 1'b0;
    n_checks++;
    if ({bus_req_o, bus_we_o, bus_addr_bo, bus_be_bo, bus_wdata_bo, busy_o} !==
        {1'b1, 1'b1, 32'h8000_0004, 4'hF, 32'h1234_5678, 1'b1}) begin
      n_fail++; $display("FAIL write_bus_fields: req=%b we=%b addr=%h be=%h wdata=%h busy=%b",
                         bus_req_o, bus_we_o, bus_addr_bo, bus_be_bo, bus_wdata_bo, busy_o);
    end
    @(negedge clk_gen);
    bus_ack_i = 1'b0;
    pop_exp(e);
    n_checks++;
    if (bus_req_o !== 1'b0 || rsp_req_o !== 1'b1 || {rsp_rdata_bo, rsp_err_o} !== e) begin
      n_fail++; $display("FAIL write_rsp_t2: bus_req=%b rsp_req=%b rdata=%h err=%b expected 0 1 %h %b",
                         bus_req_o, rsp_req_o, rsp_rdata_bo, rsp_err_o, e.rdata, e.err);
    end
    rsp_ack_i = 1'b1;
    @(negedge clk_gen);
    rsp_ack_i = 1'b0;
    n_checks++;
    if ({rsp_req_o, busy_o, cmd_ack_o, bus_we_o, bus_addr_bo, bus_be_bo, bus_wdata_bo} !==
        {1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0}) begin
      n_fail++; $display("FAIL write_return_idle: rsp_req=%b busy=%b cmd_ack=%b addr=%h be=%h wdata=%h",
                         rsp_req_o, busy_o, cmd_ack_o, bus_addr_bo, bus_be_bo, bus_wdata_bo);
    end
  endtask

  task automatic test_read_wait;
    rsp_t e;
    @(negedge clk_gen);
    send_cmd(1'b0, 32'h0000_0004, 4'hF, 32'h0);
    exp_q.push_back('{rdata: 32'h0000_A5A5, err: 1'b0});
    @(negedge clk_gen);
    cmd_req_i = 1'b0;
    n_checks++;
    if (bus_req_o !== 1'b1 || bus_we_o !== 1'b0 || bus_addr_bo !== 32'h4) begin
      n_fail++; $display("FAIL read_bus_req: req=%b we=%b addr=%h expected 1 0 00000004",
                         bus_req_o, bus_we_o, bus_addr_bo);
    end
    bus_ack_i = 1'b1;
    @(negedge clk_gen);
    bus_ack_i = 1'b0;
    n_checks++;
    if (bus_req_o !== 1'b0 || rsp_req_o !== 1'b0) begin
      n_fail++; $display("FAIL read_wait_state: bus_req=%b rsp_req=%b expected 0 0", bus_req_o, rsp_req_o);
    end
    @(negedge clk_gen);
    n_checks++;
    if (rsp_req_o !== 1'b0) begin
      n_fail++; $display("FAIL read_rsp_early: rsp_req=%b expected 0 at T+3", rsp_req_o);
    end
    bus_resp_i = 1'b1; bus_rdata_bi = 32'h0000_A5A5;
    @(negedge clk_gen);
    bus_resp_i = 1'b0; bus_rdata_bi = 32'h0;
    pop_exp(e);
    n_checks++;
    if (rsp_req_o !== 1'b1 || {rsp_rdata_bo, rsp_err_o} !== e) begin
      n_fail++; $display("FAIL read_rsp_t4: rsp_req=%b rdata=%h err=%b expected 1 %h %b",
                         rsp_req_o, rsp_rdata_bo, rsp_err_o, e.rdata, e.err);
    end
    rsp_ack_i = 1'b1;
    @(negedge clk_gen);
    rsp_ack_i = 1'b0;
  endtask

  task automatic test_timeout;
    rsp_t e;
    int   req_cycles;
    int   rsp_cycle;
    @(negedge clk_gen);
    send_cmd(1'b0, 32'h0000_0100, 4'h1, 32'h0);
    exp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b1});
    req_cycles = 0;
    rsp_cycle  = -1;
    for (int c = 1; c <= 14 && rsp_cycle < 0; c++) begin
      @(negedge clk_gen);
      cmd_req_i = 1'b0;
      if (bus_req_o === 1'b1) req_cycles++;
      if (rsp_req_o === 1'b1) rsp_cycle = c;
    end
    n_checks++;
    if (req_cycles != 8) begin
      n_fail++; $display("FAIL timeout_req_len: bus_req high %0d cycles expected 8", req_cycles);
    end
    n_checks++;
    if (rsp_cycle != 9) begin
      n_fail++; $display("FAIL timeout_rsp_cycle: rsp at T+%0d expected T+9", rsp_cycle);
    end
    pop_exp(e);
    n_checks++;
    if (bus_req_o !== 1'b0 || {rsp_rdata_bo, rsp_err_o} !== e) begin
      n_fail++; $display("FAIL timeout_rsp_data: bus_req=%b rdata=%h err=%b expected 0 %h %b",
                         bus_req_o, rsp_rdata_bo, rsp_err_o, e.rdata, e.err);
    end
    rsp_ack_i = 1'b1;
    @(negedge clk_gen);
    rsp_ack_i = 1'b0;
  endtask

  task automatic test_ack_resp_same;
    rsp_t e;
    @(negedge clk_gen);
    send_cmd(1'b0, 32'h0000_0010, 4'hF, 32'h0);
    exp_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
    @(negedge clk_gen);
    cmd_req_i = 1'b0;
    bus_ack_i = 1'b1; bus_resp_i = 1'b1; bus_rdata_bi = 32'hCAFE_F00D;
    @(negedge clk_gen);
    bus_ack_i = 1'b0; bus_resp_i = 1'b0; bus_rdata_bi = 32'h0;
    pop_exp(e);
    n_checks++;
    if (rsp_req_o !== 1'b1 || bus_req_o !== 1'b0 || {rsp_rdata_bo, rsp_err_o} !== e) begin
      n_fail++; $display("FAIL same_cycle_resp: rsp_req=%b bus_req=%b rdata=%h err=%b expected 1 0 %h %b",
                         rsp_req_o, bus_req_o, rsp_rdata_bo, rsp_err_o, e.rdata, e.err);
    end
    rsp_ack_i = 1'b1;
    @(negedge clk_gen);
    rsp_ack_i = 1'b0;
  endtask

  task automatic test_back_to_back;
    rsp_t e;
    int   bad;
    @(negedge clk_gen);
    send_cmd(1'b1, 32'h0000_0020, 4'h3, 32'h0F0F_0F0F);
    bus_ack_i = 1'b1;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    @(negedge clk_gen);
    send_cmd(1'b0, 32'h0000_0024, 4'hF, 32'h0);
    @(negedge clk_gen);
    bus_ack_i = 1'b0;
    pop_exp(e);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_req_o !== 1'b1 || {rsp_rdata_bo, rsp_err_o} !== e ||
          cmd_ack_o !== 1'b0 || bus_req_o !== 1'b0) bad++;
      @(negedge clk_gen);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rsp_hold: %0d of 5 cycles unstable, rsp_req=%b cmd_ack=%b bus_req=%b",
                         bad, rsp_req_o, cmd_ack_o, bus_req_o);
    end
    exp_q.push_back('{rdata: 32'h55AA_55AA, err: 1'b0});
    rsp_ack_i = 1'b1;
    @(negedge clk_gen);
    rsp_ack_i = 1'b0;
    n_checks++;
    if (cmd_ack_o !== 1'b1 || bus_req_o !== 1'b0 || rsp_req_o !== 1'b0) begin
      n_fail++; $display("FAIL next_accept: cmd_ack=%b bus_req=%b rsp_req=%b expected 1 0 0",
                         cmd_ack_o, bus_req_o, rsp_req_o);
    end
    @(negedge clk_gen);
    cmd_req_i = 1'b0;
    n_checks++;
    if (bus_req_o !== 1'b1 || bus_we_o !== 1'b0 || bus_addr_bo !== 32'h24) begin
      n_fail++; $display("FAIL second_bus_req: req=%b we=%b addr=%h expected 1 0 00000024",
                         bus_req_o, bus_we_o, bus_addr_bo);
    end
    bus_ack_i = 1'b1; bus_resp_i = 1'b1; bus_rdata_bi = 32'h55AA_55AA;
    @(negedge clk_gen);
    bus_ack_i = 1'b0; bus_resp_i = 1'b0; bus_rdata_bi = 32'h0;
    pop_exp(e);
    n_checks++;
    if (rsp_req_o !== 1'b1 || {rsp_rdata_bo, rsp_err_o} !== e) begin
      n_fail++; $display("FAIL second_rsp: rsp_req=%b rdata=%h err=%b expected 1 %h %b",
                         rsp_req_o, rsp_rdata_bo, rsp_err_o, e.rdata, e.err);
    end
    rsp_ack_i = 1'b1;
    @(negedge clk_gen);
    rsp_ack_i = 1'b0;
  endtask

  task automatic test_reset_mid;
    rsp_t         e;
    logic [134:0] outs;
    @(negedge clk_gen);
    send_cmd(1'b0, 32'h0000_0030, 4'hF, 32'h0);
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    @(negedge clk_gen);
    cmd_req_i = 1'b0;
    bus_ack_i = 1'b1;
    @(negedge clk_gen);
    bus_ack_i = 1'b0;
    rst_ni = 1'b0;
    bus_resp_i = 1'b1; bus_rdata_bi = 32'hBAD0_BAD0;
    exp_q.delete();
    #1;
    outs = {cmd_ack_o, rsp_req_o, rsp_rdata_bo, rsp_err_o, bus_req_o, bus_we_o,
            bus_addr_bo, bus_be_bo, bus_wdata_bo, busy_o};
    n_checks++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL async_reset_outputs: got %h expected 0", outs);
    end
    @(negedge clk_gen);
    @(negedge clk_gen);
    rst_ni = 1'b1;
    bus_resp_i = 1'b0; bus_rdata_bi = 32'h0;
    @(negedge clk_gen);
    n_checks++;
    if (rsp_req_o !== 1'b0 || busy_o !== 1'b0 || cmd_ack_o !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_idle: rsp_req=%b busy=%b cmd_ack=%b expected 0 0 1",
                         rsp_req_o, busy_o, cmd_ack_o);
    end
    send_cmd(1'b0, 32'h0000_0034, 4'hF, 32'h0);
    exp_q.push_back('{rdata: 32'h1357_9BDF, err: 1'b0});
    @(negedge clk_gen);
    cmd_req_i = 1'b0;
    bus_ack_i = 1'b1;
    @(negedge clk_gen);
    bus_ack_i = 1'b0;
    bus_resp_i = 1'b1; bus_rdata_bi = 32'h1357_9BDF;
    @(negedge clk_gen);
    bus_resp_i = 1'b0; bus_rdata_bi = 32'h0;
    pop_exp(e);
    n_checks++;
    if (rsp_req_o !== 1'b1 || {rsp_rdata_bo, rsp_err_o} !== e) begin
      n_fail++; $display("FAIL post_reset_read: rsp_req=%b rdata=%h err=%b expected 1 %h %b",
                         rsp_req_o, rsp_rdata_bo, rsp_err_o, e.rdata, e.err);
    end
    rsp_ack_i = 1'b1;
    @(negedge clk_gen);
    rsp_ack_i = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_ni = 1'b0;
    cmd_req_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_bi = '0; cmd_be_bi = '0; cmd_wdata_bi = '0;
    rsp_ack_i = 1'b0; bus_ack_i = 1'b0; bus_resp_i = 1'b0; bus_rdata_bi = '0;

    test_reset;
    test_write;
    test_read_wait;
    test_timeout;
    test_ack_resp_same;
    test_back_to_back;
    test_reset_mid;

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d responses outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
